// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared types and encoding constants for the OP/OP-IMM execute stage
package alu_exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_exec_decode.sv
// rtl/alu_exec_decode.sv - combinational legality check, field extraction and operand-B immediate
module alu_exec_decode
    import alu_exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IMM_EN = 1
) (
    input  logic [31:0]     instr,
    output logic            legal,
    output logic            is_imm,
    output logic            alt,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       is_shift;

    assign opcode   = instr[6:0];
    assign funct7   = instr[31:25];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rd       = instr[11:7];
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);

    always_comb begin
        legal  = 1'b0;
        is_imm = 1'b0;
        alt    = 1'b0;
        imm    = '0;
        if (opcode == OPCODE_OP) begin
            legal = (funct7 == FUNCT7_BASE) ||
                    ((funct7 == FUNCT7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SRL_SRA)));
            alt   = instr[30];
        end else if ((opcode == OPCODE_OP_IMM) && (IMM_EN != 0)) begin
            is_imm = 1'b1;
            if (funct3 == F3_SLL)
                legal = (funct7 == FUNCT7_BASE);
            else if (funct3 == F3_SRL_SRA)
                legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
            else
                legal = 1'b1;
            // ADDI reuses funct3=000 with arbitrary imm bits, so only SRAI may set the modifier
            alt = (funct3 == F3_SRL_SRA) && instr[30];
            // Shifts pass only the shamt so the funct7 bits never reach the ALU
            if (is_shift)
                imm = {{(XLEN-6){1'b0}}, instr[25:20]};
            else
                imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - four-state execute stage: accept, register read, external ALU, writeback
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_SELECT_LEN = 5,
    parameter int IMM_EN         = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               instruction,
    output logic [REG_SELECT_LEN-1:0] register_1,
    output logic [REG_SELECT_LEN-1:0] register_2,
    input  logic [XLEN-1:0]           register_data_1,
    input  logic [XLEN-1:0]           register_data_2,
    output logic [XLEN-1:0]           alu_a,
    output logic [XLEN-1:0]           alu_b,
    output logic [2:0]                alu_op,
    output logic                      alu_sig,
    input  logic [XLEN-1:0]           alu_out,
    output logic [REG_SELECT_LEN-1:0] output_register,
    output logic [XLEN-1:0]           output_register_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      illegal
);

    state_t            state;
    logic [31:0]       ir;
    logic [XLEN-1:0]   result;
    logic [31:0]       dec_in;
    logic              dec_legal;
    logic              dec_is_imm;
    logic              dec_alt;
    logic [2:0]        dec_funct3;
    logic [4:0]        dec_rs1;
    logic [4:0]        dec_rs2;
    logic [4:0]        dec_rd;
    logic [XLEN-1:0]   dec_imm;

    // One decoder serves both the accept check (live word) and the later stages (latched ir)
    assign dec_in = (state == IDLE) ? instruction : ir;

    alu_exec_decode #(
        .XLEN   (XLEN),
        .IMM_EN (IMM_EN)
    ) u_decode (
        .instr  (dec_in),
        .legal  (dec_legal),
        .is_imm (dec_is_imm),
        .alt    (dec_alt),
        .funct3 (dec_funct3),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .rd     (dec_rd),
        .imm    (dec_imm)
    );

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ir      <= '0;
            result  <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ir <= instruction;
                        if (dec_legal)
                            state <= READ;
                        else
                            illegal <= 1'b1;
                    end
                end
                READ: state <= EXEC;
                EXEC: begin
                    result <= alu_out;
                    state  <= WB;
                end
                WB: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every shared bus is held at zero outside the state that owns it
    always_comb begin
        register_1           = '0;
        register_2           = '0;
        alu_a                = '0;
        alu_b                = '0;
        alu_op               = '0;
        alu_sig              = 1'b0;
        output_register      = '0;
        output_register_data = '0;
        out_valid            = 1'b0;
        case (state)
            READ: begin
                register_1 = REG_SELECT_LEN'(dec_rs1);
                register_2 = REG_SELECT_LEN'(dec_rs2);
            end
            EXEC: begin
                alu_a   = register_data_1;
                alu_b   = dec_is_imm ? dec_imm : register_data_2;
                alu_op  = dec_funct3;
                alu_sig = dec_alt;
            end
            WB: begin
                out_valid            = 1'b1;
                output_register      = REG_SELECT_LEN'(dec_rd);
                output_register_data = (dec_rd != 5'd0) ? result : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench with register-file and ALU models around alu_exec_unit
module tb_alu_exec_unit;

    localparam int XLEN = 32;
    localparam int RSL  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [RSL-1:0]  register_1, register_2;
    logic [XLEN-1:0] register_data_1, register_data_2;
    logic [XLEN-1:0] alu_a, alu_b, alu_out;
    logic [2:0]      alu_op;
    logic            alu_sig;
    logic [RSL-1:0]  output_register;
    logic [XLEN-1:0] output_register_data;
    logic            out_valid;
    logic            out_ready;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] regs [32];

    alu_exec_unit #(.XLEN(XLEN), .REG_SELECT_LEN(RSL), .IMM_EN(1)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .instruction          (instruction),
        .register_1           (register_1),
        .register_2           (register_2),
        .register_data_1      (register_data_1),
        .register_data_2      (register_data_2),
        .alu_a                (alu_a),
        .alu_b                (alu_b),
        .alu_op               (alu_op),
        .alu_sig              (alu_sig),
        .alu_out              (alu_out),
        .output_register      (output_register),
        .output_register_data (output_register_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .illegal              (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        register_data_1 <= regs[register_1];
        register_data_2 <= regs[register_2];
    end

    always_comb begin
        alu_out = '0;
        case (alu_op)
            3'd0: alu_out = alu_sig ? alu_a - alu_b : alu_a + alu_b;
            3'd1: alu_out = alu_a << alu_b[4:0];
            3'd2: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'd3: alu_out = {31'd0, alu_a < alu_b};
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = alu_sig ? $unsigned($signed(alu_a) >>> alu_b[4:0]) : alu_a >> alu_b[4:0];
            3'd6: alu_out = alu_a | alu_b;
            default: alu_out = alu_a & alu_b;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (illegal) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_unexpected_illegal: got illegal=1 expected none");
                    end else begin
                        e = sb.pop_front();
                        chk("sb_illegal_kind", e.ill, 1'b1);
                    end
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_unexpected_wb: got rd=%0d data=%h expected none",
                                 output_register, output_register_data);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_wb_kind", e.ill, 1'b0);
                        chk("sb_wb_rd", output_register, e.rd);
                        chk("sb_wb_data", output_register_data, e.data);
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [31:0] instr, input logic ill, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic sig, input logic [31:0] data, input int stall);
        exp_t e;
        e.ill = ill; e.rd = rd; e.data = data;
        sb.push_back(e);
        out_ready = (stall == 0);
        chk("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        instruction = instr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        instruction = '0;
        if (ill) begin
            chk("ill_pulse", illegal, 1'b1);
            chk("ill_in_ready", in_ready, 1'b1);
            chk("ill_no_valid", out_valid, 1'b0);
            @(posedge clk); #1;
            chk("ill_pulse_end", illegal, 1'b0);
            chk("ill_still_no_valid", out_valid, 1'b0);
        end else begin
            chk("read_sel1", register_1, instr[19:15]);
            chk("read_sel2", register_2, instr[24:20]);
            chk("read_in_ready", in_ready, 1'b0);
            chk("read_alu_idle", alu_a, 32'd0);
            @(posedge clk); #1;
            chk("exec_alu_a", alu_a, a);
            chk("exec_alu_b", alu_b, b);
            chk("exec_alu_op", alu_op, op);
            chk("exec_alu_sig", alu_sig, sig);
            chk("exec_sel_idle", register_1, 5'd0);
            chk("exec_no_valid", out_valid, 1'b0);
            @(posedge clk); #1;
            chk("wb_valid", out_valid, 1'b1);
            chk("wb_in_ready", in_ready, 1'b0);
            chk("wb_alu_idle", alu_b, 32'd0);
            for (int i = 0; i < stall; i++) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_rd", output_register, rd);
                chk("stall_data", output_register_data, data);
                chk("stall_in_ready", in_ready, 1'b0);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("post_wb_in_ready", in_ready, 1'b1);
            chk("post_wb_valid", out_valid, 1'b0);
            chk("post_wb_data_idle", output_register_data, 32'd0);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[6] = 32'hFFFF_FFF0;
        rst = 1'b1; in_valid = 1'b0; instruction = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_sel1", register_1, 5'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_out_reg", output_register, 5'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // instr, ill, rd, alu_a, alu_b, op, sig, data, stall
        run_op(32'h002081B3, 0, 5'd3, 32'd5,         32'd7,         3'd0, 0, 32'd12,        0); // ADD x3,x1,x2
        run_op(32'h40335213, 0, 5'd4, 32'hFFFF_FFF0, 32'd3,         3'd5, 1, 32'hFFFF_FFFE, 0); // SRAI x4,x6,3
        run_op(32'hFFF00293, 0, 5'd5, 32'd0,         32'hFFFF_FFFF, 3'd0, 0, 32'hFFFF_FFFF, 0); // ADDI x5,x0,-1
        run_op(32'h00508013, 0, 5'd0, 32'd5,         32'd5,         3'd0, 0, 32'd0,         0); // ADDI x0,x1,5
        run_op(32'h401103B3, 0, 5'd7, 32'd7,         32'd5,         3'd0, 1, 32'd2,         0); // SUB x7,x2,x1
        run_op(32'h4020F1B3, 1, 5'd0, 32'd0,         32'd0,         3'd0, 0, 32'd0,         0); // AND with funct7 alt
        run_op(32'h0000A183, 1, 5'd0, 32'd0,         32'd0,         3'd0, 0, 32'd0,         0); // LW
        run_op(32'h02009213, 1, 5'd0, 32'd0,         32'd0,         3'd0, 0, 32'd0,         0); // SLLI shamt[5] set
        run_op(32'h0020C433, 0, 5'd8, 32'd5,         32'd7,         3'd4, 0, 32'd2,         5); // XOR x8 with stall

        // Abort an ADD during EXEC
        in_valid = 1'b1; instruction = 32'h002081B3;
        @(posedge clk); #1;
        in_valid = 1'b0; instruction = '0;
        @(posedge clk); #1;
        chk("abort_in_exec", alu_a, 32'd5);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_alu_a", alu_a, 32'd0);
        chk("abort_alu_b", alu_b, 32'd0);
        chk("abort_alu_sig", alu_sig, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_wb", out_valid, 1'b0);
        rst = 1'b0;
        #1;
        run_op(32'h0020E4B3, 0, 5'd9, 32'd5, 32'd7, 3'd6, 0, 32'd7, 0); // OR x9,x1,x2

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
